// File: rtl/game_sequencer.sv
// Dino-runner game controller: IDLE/RUN/GAP/OVER sequencing, cactus motion,
// spawn gaps, speed ramp and saturating score. Everything advances on frame_tick.
module game_sequencer #(
    parameter int CACTI_START = 550,
    parameter int CACTI_MIN   = 10,
    parameter int SPEED_INIT  = 1,
    parameter int SPEED_MAX   = 4,
    parameter int SCORE_DIV   = 32,
    parameter int SPEEDUP_PTS = 100,
    parameter int GAP_MIN     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        start,
    input  logic        collision,
    output logic        game_on,
    output logic        game_over,
    output logic [9:0]  cacti_x,
    output logic        cacti_vis,
    output logic [2:0]  speed,
    output logic [15:0] score
);
    localparam int FW = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
    localparam int PW = (SPEEDUP_PTS > 1) ? $clog2(SPEEDUP_PTS) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;
    localparam logic [1:0] OVER = 2'd3;

    logic [1:0]    state, state_nxt;
    logic          start_q;
    logic [7:0]    lfsr;
    logic [5:0]    gap_cnt;
    logic [FW-1:0] frame_cnt;
    logic [PW-1:0] pts_cnt;
    logic          start_rise, hit, retire, restart, score_tick, score_wrap;

    assign start_rise = start & ~start_q;
    assign hit        = (state == RUN) && collision && cacti_vis;
    // 11-bit compare so CACTI_MIN + speed cannot wrap; retire is checked before any subtract
    assign retire     = {1'b0, cacti_x} < (11'(CACTI_MIN) + 11'(speed));
    assign restart    = (state == OVER) && start_rise;
    assign score_tick = frame_tick && (((state == RUN) && !hit) || (state == GAP));
    assign score_wrap = score_tick && (frame_cnt == FW'(SCORE_DIV - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_rise) state_nxt = RUN;
            RUN:     if (hit) state_nxt = OVER;
                     else if (frame_tick && retire) state_nxt = GAP;
            GAP:     if (frame_tick && gap_cnt == 6'd0) state_nxt = RUN;
            OVER:    if (start_rise) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            game_on   <= 1'b0;
            game_over <= 1'b0;
            start_q   <= 1'b0;
            lfsr      <= 8'hA5;
        end else begin
            state     <= state_nxt;
            game_on   <= (state_nxt == RUN) || (state_nxt == GAP);
            game_over <= (state_nxt == OVER);
            start_q   <= start;
            lfsr      <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cacti_x   <= 10'(CACTI_START);
            cacti_vis <= 1'b1;
            gap_cnt   <= 6'd0;
        end else if (restart) begin
            cacti_x   <= 10'(CACTI_START);
            cacti_vis <= 1'b1;
        end else if (state == RUN && !hit && frame_tick) begin
            if (retire) begin
                cacti_vis <= 1'b0;
                gap_cnt   <= 6'(GAP_MIN) + {1'b0, lfsr[4:0]};
            end else begin
                cacti_x <= cacti_x - {7'd0, speed};
            end
        end else if (state == GAP && frame_tick) begin
            if (gap_cnt == 6'd0) begin
                cacti_x   <= 10'(CACTI_START);
                cacti_vis <= 1'b1;
            end else begin
                gap_cnt <= gap_cnt - 6'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || restart) begin
            frame_cnt <= '0;
            pts_cnt   <= '0;
            score     <= 16'd0;
            speed     <= 3'(SPEED_INIT);
        end else if (score_tick) begin
            if (score_wrap) begin
                frame_cnt <= '0;
                // a saturated score stops feeding the speed ramp
                if (score != 16'hFFFF) begin
                    score <= score + 16'd1;
                    if (pts_cnt == PW'(SPEEDUP_PTS - 1)) begin
                        pts_cnt <= '0;
                        if (speed != 3'(SPEED_MAX)) speed <= speed + 3'd1;
                    end else begin
                        pts_cnt <= pts_cnt + PW'(1);
                    end
                end
            end else begin
                frame_cnt <= frame_cnt + FW'(1);
            end
        end
    end
endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed scenarios plus random traffic against a
// frame-count based reference model; a second instance checks score saturation.
module tb_game_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, frame_tick, start, collision;
    logic        game_on, game_over, cacti_vis;
    logic [9:0]  cacti_x;
    logic [2:0]  speed;
    logic [15:0] score;

    logic        s_rst_n, s_tick, s_start, s_collision;
    logic        s_game_on, s_game_over, s_cacti_vis;
    logic [9:0]  s_cacti_x;
    logic [2:0]  s_speed;
    logic [15:0] s_score;

    game_sequencer dut (
        .clk(clk), .reset(rst_n), .frame_tick(frame_tick), .start(start),
        .collision(collision), .game_on(game_on), .game_over(game_over),
        .cacti_x(cacti_x), .cacti_vis(cacti_vis), .speed(speed), .score(score)
    );

    game_sequencer #(.SCORE_DIV(1)) dut_sat (
        .clk(clk), .reset(s_rst_n), .frame_tick(s_tick), .start(s_start),
        .collision(s_collision), .game_on(s_game_on), .game_over(s_game_over),
        .cacti_x(s_cacti_x), .cacti_vis(s_cacti_vis), .speed(s_speed), .score(s_score)
    );

    int total = 0;
    int bad   = 0;
    bit sat_done = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: score and speed are derived from the count of scored frames
    localparam int M_IDLE = 0, M_RUN = 1, M_GAP = 2, M_OVER = 3;
    int         m_mode = M_IDLE, m_x = 550, m_ticks = 0, m_gap = 0;
    bit         m_vis = 1'b1, m_sq = 1'b0;
    logic [7:0] m_lfsr = 8'hA5;

    function automatic int m_score();
        return (m_ticks / 32 > 65535) ? 65535 : m_ticks / 32;
    endfunction

    function automatic int m_speed();
        int s;
        s = 1 + (m_ticks / 32) / 100;
        return (s > 4) ? 4 : s;
    endfunction

    function automatic logic [31:0] m_outs();
        return {(m_mode == M_RUN || m_mode == M_GAP), (m_mode == M_OVER), 10'(m_x),
                m_vis, 3'(m_speed()), 16'(m_score())};
    endfunction

    task automatic model_edge(input logic r, input logic t, input logic s, input logic c);
        int spd;
        bit rise;
        spd  = m_speed();
        rise = s && !m_sq;
        if (!r) begin
            m_mode = M_IDLE; m_x = 550; m_vis = 1'b1; m_ticks = 0; m_gap = 0;
            m_lfsr = 8'hA5; m_sq = 1'b0;
        end else begin
            case (m_mode)
                M_IDLE: if (rise) m_mode = M_RUN;
                M_RUN: begin
                    if (c) m_mode = M_OVER;
                    else if (t) begin
                        m_ticks++;
                        if (m_x < 10 + spd) begin
                            m_mode = M_GAP; m_vis = 1'b0; m_gap = 16 + (m_lfsr % 32);
                        end else m_x -= spd;
                    end
                end
                M_GAP: if (t) begin
                    m_ticks++;
                    if (m_gap == 0) begin m_x = 550; m_vis = 1'b1; m_mode = M_RUN; end
                    else m_gap--;
                end
                default: if (rise) begin
                    m_mode = M_RUN; m_x = 550; m_vis = 1'b1; m_ticks = 0;
                end
            endcase
            m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
            m_sq   = s;
        end
    endtask

    wire logic [31:0] outs = {game_on, game_over, cacti_x, cacti_vis, speed, score};
    localparam logic [31:0] RESET_VEC = {1'b0, 1'b0, 10'd550, 1'b1, 3'd1, 16'd0};

    task automatic cyc(input logic t, input logic s, input logic c);
        frame_tick = t; start = s; collision = c;
        @(posedge clk);
        model_edge(rst_n, t, s, c);
        #1;
        chk("cycle", outs, m_outs());
    endtask

    task automatic tick_pair();
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int n, cnt, exp_len, restarts, px, ps;
        logic [7:0] l;
        bit prev_over, done;

        rst_n = 1'b0; frame_tick = 1'b0; start = 1'b0; collision = 1'b0;
        repeat (3) cyc(1'b0, 1'b0, 1'b0);
        chk("reset_outs", outs, RESET_VEC);

        rst_n = 1'b1;
        repeat (100) tick_pair();
        chk("idle_on", 32'(game_on), 32'd0);
        chk("idle_x", 32'(cacti_x), 32'd550);
        chk("idle_score", 32'(score), 32'd0);

        cyc(1'b0, 1'b1, 1'b0);
        chk("on_after_start", 32'(game_on), 32'd1);
        cyc(1'b0, 1'b0, 1'b0);
        repeat (10) tick_pair();
        chk("x_after_10", 32'(cacti_x), 32'd540);

        // run down to the retire tick, remembering the LFSR value it samples
        n = 0; done = 1'b0; l = m_lfsr;
        while (!done && n < 1000) begin
            l = m_lfsr;
            cyc(1'b1, 1'b0, 1'b0);
            n++;
            if (!cacti_vis) done = 1'b1;
            else cyc(1'b0, 1'b0, 1'b0);
        end
        chk("retire_seen", 32'(done), 32'd1);
        chk("retire_x", 32'(cacti_x), 32'd10);
        exp_len = 16 + int'(l[4:0]) + 1;
        cnt = 0;
        while (!cacti_vis && cnt < 200) begin
            cyc(1'b0, 1'b0, 1'b0);
            cyc(1'b1, 1'b0, 1'b0);
            cnt++;
        end
        chk("gap_len", 32'(cnt), 32'(exp_len));
        chk("respawn_x", 32'(cacti_x), 32'd550);

        repeat (5) tick_pair();
        px = int'(cacti_x); ps = int'(score);
        cyc(1'b1, 1'b0, 1'b1);
        chk("hit_over", 32'(game_over), 32'd1);
        chk("hit_x", 32'(cacti_x), 32'(px));
        chk("hit_score", 32'(score), 32'(ps));
        repeat (4) tick_pair();
        cyc(1'b1, 1'b0, 1'b1);
        chk("over_frozen_x", 32'(cacti_x), 32'(px));

        restarts = 0; prev_over = game_over;
        repeat (500) begin
            cyc(1'b0, 1'b1, 1'b0);
            if (prev_over && !game_over) restarts++;
            prev_over = game_over;
        end
        chk("restart_once", 32'(restarts), 32'd1);
        chk("restart_score", 32'(score), 32'd0);
        chk("restart_x", 32'(cacti_x), 32'd550);
        chk("restart_speed", 32'(speed), 32'd1);
        chk("restart_on", 32'(game_on), 32'd1);
        cyc(1'b0, 1'b0, 1'b0);

        repeat (3200) tick_pair();
        chk("score_3200", 32'(score), 32'd100);
        chk("speed_3200", 32'(speed), 32'd2);

        repeat (6000) begin
            rst_n = ($urandom % 400) != 0;
            cyc(($urandom % 3) == 0, ($urandom % 12) == 0, ($urandom % 30) == 0);
        end

        rst_n = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        repeat (40) tick_pair();
        rst_n = 1'b0;
        cyc(1'b1, 1'b1, 1'b1);
        chk("reset_priority", outs, RESET_VEC);
        rst_n = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);

        n = 0;
        while (!sat_done && n < 80000) begin
            @(posedge clk);
            n++;
        end
        chk("sat_finished", 32'(sat_done), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // One score point per frame here, so the 16-bit ceiling is reachable quickly
    initial begin
        s_rst_n = 1'b0; s_tick = 1'b0; s_start = 1'b0; s_collision = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        s_rst_n = 1'b1; s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        chk("sat_on", 32'(s_game_on), 32'd1);
        s_tick = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        chk("sat_fffe", 32'(s_score), 32'h0000FFFE);
        repeat (10) @(posedge clk);
        #1;
        chk("sat_ffff", 32'(s_score), 32'h0000FFFF);
        chk("sat_speed", 32'(s_speed), 32'd4);
        chk("sat_still_on", 32'(s_game_on), 32'd1);
        s_tick = 1'b0;
        sat_done = 1'b1;
    end
endmodule
